fb_rect_filler: RTL and testbench
=================================

Name: fb_rect_filler

Overview:
- Command-driven rectangle fill engine that sits directly upstream of the frame buffer write port.
- Accepts one rectangle command (x, y, w, h, colour) over valid/ready, clips it to the screen, and streams row-major pixel writes (address + data) with backpressure.
- memory_system instantiates it and arbitrates its write stream onto the frame-buffer WRITE path.

Parameters:
- FB_WIDTH, 320, horizontal resolution in pixels.
- FB_HEIGHT, 180, vertical resolution in pixels.
- PIXEL_W, 8, colour bits per pixel.
- COORD_W, 10, width of cmd_x/y/w/h; must satisfy 2^COORD_W > max(FB_WIDTH, FB_HEIGHT).
- ADDR_W, $clog2(FB_WIDTH*FB_HEIGHT), frame-buffer word address width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine can accept a command.
- cmd_x  input  COORD_W  left column (unsigned).
- cmd_y  input  COORD_W  top row (unsigned).
- cmd_w  input  COORD_W  width in pixels.
- cmd_h  input  COORD_W  height in pixels.
- cmd_color  input  PIXEL_W  fill colour.
- wr_valid  output  1  pixel write request.
- wr_ready  input  1  frame buffer accepts write.
- wr_addr  output  ADDR_W  linear address y*FB_WIDTH+x.
- wr_data  output  PIXEL_W  pixel colour.
- busy  output  1  high from command accept until done.
- done  output  1  one-cycle pulse at end of each command.

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE, cmd_ready=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0. Reset mid-fill aborts immediately, with no done pulse.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid && cmd_ready, latch the command and go to CLIP.
  - CLIP: one cycle, no writes.
    - Clipped bounds: x1=min(x+w,FB_WIDTH), y1=min(y+h,FB_HEIGHT), computed in COORD_W+1 bits so there is no overflow.
    - Empty if w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT.
    - Empty: go to IDLE and assert done next cycle.
    - Non-empty: register row_base=y*FB_WIDTH+x (constant multiply) and go to FILL.
  - FILL: wr_valid=1, with wr_addr/wr_data from registers.
    - On each handshake (wr_valid && wr_ready), advance the column.
    - At column x1-1, advance the row and set addr=row_base+FB_WIDTH (no multiplier in FILL).
    - After the final pixel (x1-1, y1-1) handshakes, go to IDLE and pulse done on the following cycle.
- Latency: command accepted in cycle T → CLIP in T+1 → first wr_valid in T+2.
- Throughput: one pixel per cycle while wr_ready=1.
- Backpressure: while wr_valid && !wr_ready, wr_addr/wr_data/wr_valid hold stable. No pixel is dropped or duplicated.
- busy: 1 in CLIP and FILL, 0 in IDLE.
- cmd_ready: low whenever not IDLE. A command presented during busy stalls and is not lost (upstream holds it).
- done and cmd_ready may both be high in the same cycle; a new command may be accepted that cycle.
- cmd_* inputs are sampled only at the accept handshake; later changes are ignored.
- Writes are row-major, left→right, top→bottom. Addresses are strictly increasing within a command.

Decomposition:
- fb_pkg holds:
  - FB_WIDTH, FB_HEIGHT, PIXEL_W, FB_ADDR_W constants;
  - typedef rect_cmd_t (struct: x, y, w, h, color);
  - typedef fill_state_t (enum IDLE, CLIP, FILL).
- Sub-module rect_clipper: purely combinational; takes rect_cmd_t and produces x0, x1, y0, y1, empty and start address. Registered by the parent in CLIP.

Test Plan:
1. Cmd (x=3,y=1,w=2,h=2,color=0xA5), wr_ready=1 → writes to addrs 323, 324, 643, 644, all data 0xA5; first wr_valid 2 cycles after accept; done one cycle after the 4th handshake; busy low after.
2. Clipping: (x=318,y=179,w=5,h=3) → exactly 2 writes, addrs 57598 and 57599; then done.
3. Empty: w=0, and separately x=320 → zero wr_valid cycles; done pulses 2 cycles after accept.
4. Backpressure: 4x3 fill with wr_ready toggling pseudo-randomly → exactly 12 handshakes, correct addresses in order, outputs stable during stalls.
5. Busy stall: second command asserted during the fill → cmd_ready=0 until done; second command accepted on the done cycle and executed fully afterwards.
6. Reset mid-fill: assert rst_in low after 5 of 20 writes → wr_valid=0, busy=0, done=0 asynchronously; a new command after release fills correctly from its first pixel.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the rectangle fill engine.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;
  localparam int PIXEL_W   = 8;
  localparam int COORD_W   = 10;
  localparam int FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT);

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [PIXEL_W-1:0] color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    FILL
  } fill_state_t;

endpackage

// File: rtl/fb_rect_filler_if.sv
// Command and pixel-write valid/ready buses of the rectangle fill engine.
interface rect_cmd_if;
  import fb_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [COORD_W-1:0] cmd_w;
  logic [COORD_W-1:0] cmd_h;
  logic [PIXEL_W-1:0] cmd_color;

  modport master (output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
                  output cmd_ready);
endinterface

interface pix_wr_if;
  import fb_pkg::*;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic [PIXEL_W-1:0]   wr_data;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input  wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/rect_clipper.sv
// Combinational clip of a rectangle command against the screen bounds.
module rect_clipper
  import fb_pkg::*;
(
  input  rect_cmd_t            cmd_i,
  output logic [COORD_W:0]     x0_o,
  output logic [COORD_W:0]     x1_o,
  output logic [COORD_W:0]     y0_o,
  output logic [COORD_W:0]     y1_o,
  output logic                 empty_o,
  output logic [FB_ADDR_W-1:0] start_addr_o
);

  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(FB_WIDTH);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(FB_HEIGHT);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  always_comb begin
    // One extra bit keeps x+w / y+h from wrapping before the min().
    x_end        = {1'b0, cmd_i.x} + {1'b0, cmd_i.w};
    y_end        = {1'b0, cmd_i.y} + {1'b0, cmd_i.h};
    x0_o         = {1'b0, cmd_i.x};
    y0_o         = {1'b0, cmd_i.y};
    x1_o         = (x_end > W_LIM) ? W_LIM : x_end;
    y1_o         = (y_end > H_LIM) ? H_LIM : y_end;
    empty_o      = (cmd_i.w == '0) || (cmd_i.h == '0) ||
                   ({1'b0, cmd_i.x} >= W_LIM) || ({1'b0, cmd_i.y} >= H_LIM);
    start_addr_o = FB_ADDR_W'(cmd_i.y) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(cmd_i.x);
  end

endmodule

// File: rtl/fb_rect_filler.sv
// Rectangle fill engine: accepts a command, clips it, streams row-major pixel writes.
module fb_rect_filler
  import fb_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  rect_cmd_if.slave    cmd,
  pix_wr_if.master     wr,
  output logic         busy,
  output logic         done
);

  fill_state_t          state_q;
  rect_cmd_t            cmd_q;
  logic                 cmd_ready_q;
  logic                 wr_valid_q;
  logic [FB_ADDR_W-1:0] addr_q;
  logic [FB_ADDR_W-1:0] row_base_q;
  logic [PIXEL_W-1:0]   data_q;
  logic [COORD_W:0]     x0_q;
  logic [COORD_W:0]     x1_q;
  logic [COORD_W:0]     y1_q;
  logic [COORD_W:0]     col_q;
  logic [COORD_W:0]     row_q;
  logic                 busy_q;
  logic                 done_q;

  logic [COORD_W:0]     clip_x0;
  logic [COORD_W:0]     clip_x1;
  logic [COORD_W:0]     clip_y0;
  logic [COORD_W:0]     clip_y1;
  logic                 clip_empty;
  logic [FB_ADDR_W-1:0] clip_start;

  localparam logic [COORD_W:0]     ONE      = (COORD_W+1)'(1);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(FB_WIDTH);

  rect_clipper u_clipper (
    .cmd_i        (cmd_q),
    .x0_o         (clip_x0),
    .x1_o         (clip_x1),
    .y0_o         (clip_y0),
    .y1_o         (clip_y1),
    .empty_o      (clip_empty),
    .start_addr_o (clip_start)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_valid_q  <= 1'b0;
      addr_q      <= '0;
      row_base_q  <= '0;
      data_q      <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd.cmd_valid && cmd_ready_q) begin
            cmd_q.x     <= cmd.cmd_x;
            cmd_q.y     <= cmd.cmd_y;
            cmd_q.w     <= cmd.cmd_w;
            cmd_q.h     <= cmd.cmd_h;
            cmd_q.color <= cmd.cmd_color;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= CLIP;
          end
        end
        CLIP: begin
          if (clip_empty) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end else begin
            x0_q       <= clip_x0;
            x1_q       <= clip_x1;
            y1_q       <= clip_y1;
            col_q      <= clip_x0;
            row_q      <= clip_y0;
            row_base_q <= clip_start;
            addr_q     <= clip_start;
            data_q     <= cmd_q.color;
            wr_valid_q <= 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          // wr_valid is always high here, so wr_ready alone marks a handshake.
          if (wr.wr_ready) begin
            if (col_q == x1_q - ONE) begin
              if (row_q == y1_q - ONE) begin
                wr_valid_q  <= 1'b0;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= IDLE;
              end else begin
                row_q      <= row_q + ONE;
                col_q      <= x0_q;
                row_base_q <= row_base_q + ROW_STEP;
                addr_q     <= row_base_q + ROW_STEP;
              end
            end else begin
              col_q  <= col_q + ONE;
              addr_q <= addr_q + FB_ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign wr.wr_valid   = wr_valid_q;
  assign wr.wr_addr    = addr_q;
  assign wr.wr_data    = data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Directed testbench for fb_rect_filler; stimulus and sampling on the falling edge.
module tb_fb_rect_filler;
  import fb_pkg::*;

  logic clk;
  logic rst_n;
  logic busy;
  logic done;

  rect_cmd_if cmd_bus ();
  pix_wr_if   wr_bus ();

  fb_rect_filler dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .cmd    (cmd_bus),
    .wr     (wr_bus),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int hs_addr[$];
  int hs_data[$];
  int first_valid, done_cyc, last_hs, stall_err, valid_cnt, accept_cyc, rdy_busy_err, stall_cnt;
  logic [31:0] ready_pat;

  task automatic send_cmd(input int x, input int y, input int w, input int h, input int c);
    cmd_bus.cmd_x     = COORD_W'(x);
    cmd_bus.cmd_y     = COORD_W'(y);
    cmd_bus.cmd_w     = COORD_W'(w);
    cmd_bus.cmd_h     = COORD_W'(h);
    cmd_bus.cmd_color = PIXEL_W'(c);
    cmd_bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_bus.cmd_ready) break;
      @(negedge clk);
    end
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout cmd_ready=%b required 1", cmd_bus.cmd_ready);
    end
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Runs from the CLIP cycle (k=1) until done, recording handshakes and stalls.
  task automatic collect(input int budget, input bit rand_ready, input bit queue_b,
                         input int bx, input int by, input int bw, input int bh, input int bc);
    bit prev_stall;
    int pa, pd;
    hs_addr.delete();
    hs_data.delete();
    first_valid = -1; done_cyc = -1; last_hs = -1; stall_err = 0; stall_cnt = 0;
    valid_cnt = 0; accept_cyc = -1; rdy_busy_err = 0;
    prev_stall = 1'b0; pa = 0; pd = 0;
    for (int k = 1; k <= budget; k++) begin
      wr_bus.wr_ready = rand_ready ? ready_pat[k % 32] : 1'b1;
      if (queue_b && k == 2) begin
        cmd_bus.cmd_x     = COORD_W'(bx);
        cmd_bus.cmd_y     = COORD_W'(by);
        cmd_bus.cmd_w     = COORD_W'(bw);
        cmd_bus.cmd_h     = COORD_W'(bh);
        cmd_bus.cmd_color = PIXEL_W'(bc);
        cmd_bus.cmd_valid = 1'b1;
      end
      if (busy && cmd_bus.cmd_ready) rdy_busy_err++;
      if (prev_stall && (!wr_bus.wr_valid || int'(wr_bus.wr_addr) != pa || int'(wr_bus.wr_data) != pd))
        stall_err++;
      if (wr_bus.wr_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = k;
      end
      if (wr_bus.wr_valid && wr_bus.wr_ready) begin
        hs_addr.push_back(int'(wr_bus.wr_addr));
        hs_data.push_back(int'(wr_bus.wr_data));
        last_hs = k;
      end
      if (wr_bus.wr_valid && !wr_bus.wr_ready) stall_cnt++;
      prev_stall = wr_bus.wr_valid && !wr_bus.wr_ready;
      pa = int'(wr_bus.wr_addr);
      pd = int'(wr_bus.wr_data);
      if (done) begin
        done_cyc = k;
        if (queue_b && cmd_bus.cmd_valid && cmd_bus.cmd_ready) accept_cyc = k;
        break;
      end
      @(negedge clk);
    end
    if (queue_b) begin
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b0;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_x = '0; cmd_bus.cmd_y = '0; cmd_bus.cmd_w = '0; cmd_bus.cmd_h = '0;
    cmd_bus.cmd_color = '0;
    wr_bus.wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_bus.cmd_ready !== 1'b1 || wr_bus.wr_valid !== 1'b0 || wr_bus.wr_addr !== '0 ||
        wr_bus.wr_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b vld=%b addr=%0d data=%0d busy=%b done=%b required 1 0 0 0 0 0",
               cmd_bus.cmd_ready, wr_bus.wr_valid, wr_bus.wr_addr, wr_bus.wr_data, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: checked idle outputs");
  endtask

  task automatic test_basic();
    int exp_a[4] = '{323, 324, 643, 644};
    send_cmd(3, 1, 2, 2, 'hA5);
    collect(50, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (hs_addr.size() != 4) begin
      errors++; $display("FAIL basic_count got %0d required 4", hs_addr.size());
    end
    for (int i = 0; i < 4 && i < hs_addr.size(); i++) begin
      checks++;
      if (hs_addr[i] != exp_a[i] || hs_data[i] != 'hA5) begin
        errors++;
        $display("FAIL basic_pix%0d addr=%0d data=%0h required %0d a5", i, hs_addr[i], hs_data[i], exp_a[i]);
      end
    end
    checks++;
    if (first_valid != 2) begin errors++; $display("FAIL basic_latency got %0d required 2", first_valid); end
    checks++;
    if (done_cyc != 6 || last_hs != 5) begin
      errors++; $display("FAIL basic_done_cyc done=%0d last_hs=%0d required 6 5", done_cyc, last_hs);
    end
    checks++;
    if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle busy=%b rdy=%b required 0 1", busy, cmd_bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse done=%b required 0", done); end
    $display("basic: 3,1 2x2 -> %0d writes, done at cycle %0d", hs_addr.size(), done_cyc);
  endtask

  task automatic test_clip();
    send_cmd(318, 179, 5, 3, 'h3C);
    collect(50, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (hs_addr.size() != 2) begin
      errors++; $display("FAIL clip_count got %0d required 2", hs_addr.size());
    end else begin
      checks++;
      if (hs_addr[0] != 57598 || hs_addr[1] != 57599 || hs_data[1] != 'h3C) begin
        errors++;
        $display("FAIL clip_addr got %0d %0d data %0h required 57598 57599 3c", hs_addr[0], hs_addr[1], hs_data[1]);
      end
    end
    checks++;
    if (done_cyc != last_hs + 1) begin
      errors++; $display("FAIL clip_done done=%0d last_hs=%0d required last_hs+1", done_cyc, last_hs);
    end
    $display("clip: 318,179 5x3 -> %0d writes", hs_addr.size());
  endtask

  task automatic test_empty();
    send_cmd(5, 5, 0, 4, 'h11);
    collect(20, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_cnt != 0 || done_cyc != 2) begin
      errors++; $display("FAIL empty_w0 valid=%0d done=%0d required 0 2", valid_cnt, done_cyc);
    end
    $display("empty: w=0 -> %0d valid cycles, done at %0d", valid_cnt, done_cyc);
    send_cmd(320, 0, 4, 4, 'h22);
    collect(20, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_cnt != 0 || done_cyc != 2) begin
      errors++; $display("FAIL empty_x320 valid=%0d done=%0d required 0 2", valid_cnt, done_cyc);
    end
    $display("empty: x=320 -> %0d valid cycles, done at %0d", valid_cnt, done_cyc);
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    ready_pat = 32'h9B3A_6C5D;
    send_cmd(10, 5, 4, 3, 'h5A);
    collect(200, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    wr_bus.wr_ready = 1'b1;
    checks++;
    if (hs_addr.size() != 12) begin
      errors++; $display("FAIL bp_count got %0d required 12", hs_addr.size());
    end
    ok = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        base = (5 + r) * 320 + 10 + c;
        if (r * 4 + c >= hs_addr.size() || hs_addr[r*4+c] != base || hs_data[r*4+c] != 'h5A) ok = 1'b0;
      end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_order addresses not 1610..1613,1930..1933,2250..2253"); end
    checks++;
    if (stall_err != 0 || stall_cnt == 0) begin
      errors++; $display("FAIL bp_stable unstable=%0d stalls=%0d required 0 and >0", stall_err, stall_cnt);
    end
    $display("backpressure: 4x3 -> %0d writes, %0d stall cycles", hs_addr.size(), stall_cnt);
  endtask

  task automatic test_back_to_back();
    send_cmd(0, 0, 2, 2, 'h77);
    collect(50, 1'b0, 1'b1, 100, 2, 3, 1, 'h99);
    checks++;
    if (rdy_busy_err != 0) begin
      errors++; $display("FAIL b2b_ready_busy cycles=%0d required 0", rdy_busy_err);
    end
    checks++;
    if (accept_cyc != done_cyc || hs_addr.size() != 4 || hs_addr[3] != 321) begin
      errors++;
      $display("FAIL b2b_accept accept=%0d done=%0d n=%0d required accept==done n=4", accept_cyc, done_cyc, hs_addr.size());
    end
    collect(50, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (hs_addr.size() != 3 || hs_addr[0] != 740 || hs_addr[2] != 742 || hs_data[0] != 'h99 ||
        first_valid != 2) begin
      errors++;
      $display("FAIL b2b_second n=%0d first=%0d first_valid=%0d required 3 740 2",
               hs_addr.size(), hs_addr.size() > 0 ? hs_addr[0] : -1, first_valid);
    end
    $display("back_to_back: second command accepted at cycle %0d, %0d writes", accept_cyc, hs_addr.size());
  endtask

  task automatic test_reset_mid_fill();
    int n;
    bit seen_done;
    n = 0;
    send_cmd(50, 10, 20, 1, 'hC3);
    wr_bus.wr_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (n == 5) break;
      if (wr_bus.wr_valid) n++;
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_bus.wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async vld=%b busy=%b done=%b rdy=%b required 0 0 0 1",
               wr_bus.wr_valid, busy, done, cmd_bus.cmd_ready);
    end
    seen_done = 1'b0;
    repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
    checks++;
    if (seen_done) begin errors++; $display("FAIL rst_no_done done pulsed after abort, required none"); end
    send_cmd(7, 0, 3, 1, 'h0F);
    collect(50, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    checks++;
    if (hs_addr.size() != 3 || hs_addr[0] != 7 || hs_addr[1] != 8 || hs_addr[2] != 9 || hs_data[2] != 'h0F) begin
      errors++;
      $display("FAIL rst_refill n=%0d first=%0d required 3 7", hs_addr.size(), hs_addr.size() > 0 ? hs_addr[0] : -1);
    end
    $display("reset_mid_fill: aborted after %0d writes, refill -> %0d writes", n, hs_addr.size());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ready_pat = 32'hFFFF_FFFF;
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
